// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main controller.
// The TRAP state exists only when MC_CTRL_TRAP_EN is defined.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
`ifdef MC_CTRL_TRAP_EN
    S_JR       = 4'd13,
    S_TRAP     = 4'd14
`else
    S_JR       = 4'd13
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_A      = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Pure state -> datapath control decoder. opcode only refines I_EXEC and
// BRANCH; mem_ready only gates the FETCH register writes.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       imm_zero_ext,
  output logic [1:0] mem_to_reg,
  output logic [1:0] reg_dst,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    imm_zero_ext  = 1'b0;
    mem_to_reg    = M2R_ALUOUT;
    reg_dst       = RDST_RT;
    alu_src_b     = SRCB_B;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    case (state_t'(state))
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_4;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = SRCB_IMM2;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = RDST_RD;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        // ori zero-extends its immediate and uses the OR ALU mode
        if (opcode == OP_ORI) begin
          alu_op       = ALUOP_OR;
          imm_zero_ext = 1'b1;
        end
      end
      S_I_WB:     reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        branch_ne     = (opcode == OP_BNE);
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        reg_write  = 1'b1;
        reg_dst    = RDST_RA;
        mem_to_reg = M2R_PC;
      end
      S_JR: begin
        alu_src_a = 1'b1;
        pc_write  = 1'b1;
        pc_source = PCSRC_A;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS main controller: state register, dispatch and retire counter.
// Define MC_CTRL_TRAP_EN to trap unknown opcodes instead of treating them as NOPs.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W  = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  opcode,
  input  logic [OP_W-1:0]  funct,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNe,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic             ImmZeroExt,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       RegDst,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             illegal_op,
  output logic [3:0]       dbg_state
);

  state_t state, next_state;
  logic   pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:       next_state = (funct == FN_JR) ? S_JR : S_R_EXEC;
          OP_LW, OP_SW:   next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_ADDI, OP_ORI: next_state = S_I_EXEC;
          OP_J:           next_state = S_JUMP;
          OP_JAL:         next_state = S_JAL;
`ifdef MC_CTRL_TRAP_EN
          default:        next_state = S_TRAP;
`else
          default:        next_state = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) next_state = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) next_state = S_FETCH;
      S_R_EXEC:   next_state = S_R_WB;
      S_I_EXEC:   next_state = S_I_WB;
`ifdef MC_CTRL_TRAP_EN
      S_TRAP:     next_state = S_TRAP;
`endif
      default:    next_state = S_FETCH;
    endcase
  end

  // Every path back to FETCH from elsewhere is the last cycle of an instruction
  assign instr_done = rst_n && (state != S_FETCH) && (next_state == S_FETCH);

  always_ff @(posedge clk) begin
    if (!rst_n)          retired <= '0;
    else if (instr_done) retired <= retired + CNT_W'(1);
  end

`ifdef MC_CTRL_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                    illegal_op <= 1'b0;
    else if (next_state == S_TRAP) illegal_op <= 1'b1;
  end
`else
  assign illegal_op = 1'b0;
`endif

  mc_ctrl_outdec u_outdec (
    .state         (state),
    .opcode        (opcode[5:0]),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (BranchNe),
    .iord          (IorD),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .alu_src_a     (ALUSrcA),
    .imm_zero_ext  (ImmZeroExt),
    .mem_to_reg    (MemtoReg),
    .reg_dst       (RegDst),
    .alu_src_b     (ALUSrcB),
    .alu_op        (ALUOp),
    .pc_source     (PCSource)
  );

  // Architectural strobes are held off combinationally while reset is asserted
  assign PCWrite     = pc_write      & rst_n;
  assign PCWriteCond = pc_write_cond & rst_n;
  assign MemRead     = mem_read      & rst_n;
  assign MemWrite    = mem_write     & rst_n;
  assign IRWrite     = ir_write      & rst_n;
  assign RegWrite    = reg_write     & rst_n;
  assign dbg_state   = state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit; CNT_W=4 so the retire counter wraps quickly.
module tb_mc_control_unit;
  import mc_ctrl_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       opcode, funct;
  logic             mem_ready;
  logic             PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite;
  logic             IRWrite, RegWrite, ALUSrcA, ImmZeroExt;
  logic [1:0]       MemtoReg, RegDst, ALUSrcB, ALUOp, PCSource;
  logic             instr_done, illegal_op;
  logic [CNT_W-1:0] retired;
  logic [3:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int exp_ret  = 0;

  mc_control_unit #(.OP_W(6), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ImmZeroExt(ImmZeroExt), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .instr_done(instr_done),
    .retired(retired), .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  // clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (errors=%0d)", n_errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic start(input logic [5:0] op, input logic [5:0] fn);
    opcode    = op;
    funct     = fn;
    mem_ready = 1'b1;
    #1;
  endtask

  // Called in the expected last cycle of an instruction.
  task automatic finish_instr(input string tag);
    check({tag, "_done"}, instr_done, 1);
    tick(1);
    exp_ret++;
    check({tag, "_ret"}, retired, exp_ret % 16);
    check({tag, "_fetch"}, dbg_state, S_FETCH);
    check({tag, "_done_clr"}, instr_done, 0);
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; opcode = '0; funct = '0;
    tick(2);
    check("rst_state", dbg_state, S_FETCH);
    check("rst_memread", MemRead, 0);
    check("rst_irwrite", IRWrite, 0);
    check("rst_pcwrite", PCWrite, 0);
    check("rst_ret", retired, 0);
    check("rst_illegal", illegal_op, 0);
    check("rst_done", instr_done, 0);

    rst_n = 1'b1; mem_ready = 1'b0; #1;
    check("stall_memread", MemRead, 1);
    check("stall_srcb", ALUSrcB, SRCB_4);
    check("stall_irwrite", IRWrite, 0);
    check("stall_pcwrite", PCWrite, 0);
    tick(1);
    check("stall_state", dbg_state, S_FETCH);

    // lw, 5 cycles
    start(OP_LW, 6'h00);
    check("lw_c1_irwrite", IRWrite, 1);
    check("lw_c1_pcwrite", PCWrite, 1);
    tick(1);
    check("lw_c2_state", dbg_state, S_DECODE);
    check("lw_c2_srcb", ALUSrcB, SRCB_IMM2);
    check("lw_c2_aluop", ALUOp, ALUOP_ADD);
    tick(1);
    check("lw_c3_state", dbg_state, S_MEM_ADDR);
    check("lw_c3_srca", ALUSrcA, 1);
    check("lw_c3_srcb", ALUSrcB, SRCB_IMM);
    tick(1);
    check("lw_c4_state", dbg_state, S_MEM_RD);
    check("lw_c4_iord", IorD, 1);
    check("lw_c4_memread", MemRead, 1);
    tick(1);
    check("lw_c5_state", dbg_state, S_MEM_WB);
    check("lw_c5_regwrite", RegWrite, 1);
    check("lw_c5_memtoreg", MemtoReg, M2R_MDR);
    check("lw_c5_regdst", RegDst, RDST_RT);
    finish_instr("lw");

    // R-type add, 4 cycles
    start(OP_RTYPE, 6'h20);
    tick(2);
    check("add_c3_state", dbg_state, S_R_EXEC);
    check("add_c3_aluop", ALUOp, ALUOP_FUNCT);
    check("add_c3_srca", ALUSrcA, 1);
    check("add_c3_srcb", ALUSrcB, SRCB_B);
    tick(1);
    check("add_c4_regwrite", RegWrite, 1);
    check("add_c4_regdst", RegDst, RDST_RD);
    check("add_c4_memtoreg", MemtoReg, M2R_ALUOUT);
    finish_instr("add");

    // jr, 3 cycles
    start(OP_RTYPE, FN_JR);
    tick(2);
    check("jr_state", dbg_state, S_JR);
    check("jr_pcsrc", PCSource, PCSRC_A);
    check("jr_pcwrite", PCWrite, 1);
    check("jr_regwrite", RegWrite, 0);
    finish_instr("jr");

    // addi and ori, 4 cycles
    start(OP_ADDI, 6'h00);
    tick(2);
    check("addi_aluop", ALUOp, ALUOP_ADD);
    check("addi_zext", ImmZeroExt, 0);
    check("addi_srcb", ALUSrcB, SRCB_IMM);
    tick(1);
    check("addi_regwrite", RegWrite, 1);
    check("addi_regdst", RegDst, RDST_RT);
    finish_instr("addi");

    start(OP_ORI, 6'h00);
    tick(2);
    check("ori_aluop", ALUOp, ALUOP_OR);
    check("ori_zext", ImmZeroExt, 1);
    tick(1);
    check("ori_regwrite", RegWrite, 1);
    finish_instr("ori");

    // sw with 3 wait cycles in MEM_WR: 7 cycles total
    start(OP_SW, 6'h00);
    tick(3);
    check("sw_state", dbg_state, S_MEM_WR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sw_wait_memwrite", MemWrite, 1);
      check("sw_wait_iord", IorD, 1);
      check("sw_wait_done", instr_done, 0);
      tick(1);
    end
    mem_ready = 1'b1; #1;
    check("sw_last_memwrite", MemWrite, 1);
    finish_instr("sw");

    // beq, bne
    start(OP_BEQ, 6'h00);
    tick(2);
    check("beq_pwc", PCWriteCond, 1);
    check("beq_aluop", ALUOp, ALUOP_SUB);
    check("beq_ne", BranchNe, 0);
    check("beq_pcsrc", PCSource, PCSRC_ALUOUT);
    finish_instr("beq");

    start(OP_BNE, 6'h00);
    tick(2);
    check("bne_pwc", PCWriteCond, 1);
    check("bne_ne", BranchNe, 1);
    finish_instr("bne");

    // j, jal
    start(OP_J, 6'h00);
    tick(2);
    check("j_pcwrite", PCWrite, 1);
    check("j_pcsrc", PCSource, PCSRC_JUMP);
    check("j_regwrite", RegWrite, 0);
    finish_instr("j");

    start(OP_JAL, 6'h00);
    tick(2);
    check("jal_regdst", RegDst, RDST_RA);
    check("jal_memtoreg", MemtoReg, M2R_PC);
    check("jal_pcwrite", PCWrite, 1);
    check("jal_regwrite", RegWrite, 1);
    finish_instr("jal");

    // unknown opcode
    start(6'h3F, 6'h00);
    tick(1);
    check("bad_decode", dbg_state, S_DECODE);
`ifdef MC_CTRL_TRAP_EN
    check("trap_nodone", instr_done, 0);
    tick(1);
    check("trap_state", dbg_state, S_TRAP);
    check("trap_flag", illegal_op, 1);
    tick(3);
    check("trap_hold", dbg_state, S_TRAP);
    check("trap_memread", MemRead, 0);
    check("trap_pcwrite", PCWrite, 0);
    check("trap_ret", retired, exp_ret % 16);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1; #1;
    exp_ret = 0;
    check("trap_rst_state", dbg_state, S_FETCH);
    check("trap_rst_flag", illegal_op, 0);
    check("trap_rst_ret", retired, 0);
`else
    finish_instr("nop");
    check("nop_illegal", illegal_op, 0);
`endif

    // reset while in MEM_RD
    start(OP_LW, 6'h00);
    tick(3);
    check("rstrd_state", dbg_state, S_MEM_RD);
    rst_n = 1'b0; #1;
    check("rstrd_memread", MemRead, 0);
    check("rstrd_done", instr_done, 0);
    tick(1);
    check("rstrd_fetch", dbg_state, S_FETCH);
    check("rstrd_ret", retired, 0);
    rst_n = 1'b1;
    exp_ret = 0;

    // 16 jumps wrap the 4-bit counter
    for (int i = 0; i < 15; i++) begin
      start(OP_J, 6'h00);
      tick(2);
      finish_instr("wrapj");
    end
    check("wrap_full", retired, 4'hF);
    start(OP_J, 6'h00);
    tick(2);
    finish_instr("wrapj_last");
    check("wrap_zero", retired, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
